// File: rtl/bit_serial_alu_if.sv
// Start/busy/done handshake and operand/result bus of the bit-serial ALU.
// The controller drives the master side and the ALU is the slave.
interface bit_serial_alu_if #(
  parameter int unsigned WIDTH = 64
) ();
  logic             start;
  logic [3:0]       ALUOp;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Result;
  logic             Zero;
  logic             CarryOut;
  logic             Overflow;

  modport master (
    output start, ALUOp, a, b,
    input  busy, done, Result, Zero, CarryOut, Overflow
  );

  modport slave (
    input  start, ALUOp, a, b,
    output busy, done, Result, Zero, CarryOut, Overflow
  );
endinterface

// File: rtl/bit_serial_alu.sv
// Bit-serial ALU: one 1-bit AND/OR/NOR/ADD/SUB/SLT slice reused over WIDTH cycles,
// LSB first, with a carry register closing the ripple loop.
module bit_serial_alu #(
  parameter int unsigned WIDTH = 64
) (
  input logic             clk,
  input logic             reset,
  bit_serial_alu_if.slave alu_if
);

  localparam int unsigned CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [3:0]         op_q, op_d;
  logic               c_q, c_d;
  logic               c_msb_q, c_msb_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               zero_q, zero_d;
  logic               carry_out_q, carry_out_d;
  logic               overflow_q, overflow_d;

  logic               load_sub;
  logic               sum_bit;
  logic               carry_nx;
  logic               res_bit;
  logic               is_arith;
  logic               ovf;

  // Next-state, datapath step and output capture
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    acc_d       = acc_q;
    op_d        = op_q;
    c_d         = c_q;
    c_msb_d     = c_msb_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    result_d    = result_q;
    zero_d      = zero_q;
    carry_out_d = carry_out_q;
    overflow_d  = overflow_q;

    load_sub = (alu_if.ALUOp == OP_SUB) || (alu_if.ALUOp == OP_SLT);
    sum_bit  = a_q[0] ^ b_q[0] ^ c_q;
    carry_nx = (a_q[0] & b_q[0]) | (a_q[0] & c_q) | (b_q[0] & c_q);
    is_arith = (op_q == OP_ADD) || (op_q == OP_SUB) || (op_q == OP_SLT);
    ovf      = c_msb_q ^ c_q;

    unique case (op_q)
      OP_AND:                 res_bit = a_q[0] & b_q[0];
      OP_OR:                  res_bit = a_q[0] | b_q[0];
      OP_NOR:                 res_bit = ~(a_q[0] | b_q[0]);
      OP_ADD, OP_SUB, OP_SLT: res_bit = sum_bit;
      default:                res_bit = 1'b0;
    endcase

    unique case (state_q)
      IDLE: begin
        if (alu_if.start) begin
          state_d = RUN;
          a_d     = alu_if.a;
          b_d     = load_sub ? ~alu_if.b : alu_if.b;
          op_d    = alu_if.ALUOp;
          c_d     = load_sub;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end
      end
      RUN: begin
        acc_d = {res_bit, acc_q[WIDTH-1:1]};
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        c_d   = carry_nx;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          c_msb_d = c_q;
          state_d = FINISH;
        end else begin
          cnt_d = CNT_W'(cnt_q + 1'b1);
        end
      end
      FINISH: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        // SLT takes the sign of the difference, corrected for overflow
        if (op_q == OP_SLT) begin
          result_d = WIDTH'(acc_q[WIDTH-1] ^ ovf);
        end else if (is_arith || op_q == OP_AND || op_q == OP_OR || op_q == OP_NOR) begin
          result_d = acc_q;
        end else begin
          result_d = '0;
        end
        zero_d      = (result_d == '0);
        carry_out_d = is_arith & c_q;
        overflow_d  = is_arith & ovf;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      op_q        <= '0;
      c_q         <= 1'b0;
      c_msb_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      op_q        <= op_d;
      c_q         <= c_d;
      c_msb_q     <= c_msb_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      carry_out_q <= carry_out_d;
      overflow_q  <= overflow_d;
    end
  end

  assign alu_if.busy     = busy_q;
  assign alu_if.done     = done_q;
  assign alu_if.Result   = result_q;
  assign alu_if.Zero     = zero_q;
  assign alu_if.CarryOut = carry_out_q;
  assign alu_if.Overflow = overflow_q;

endmodule
